// File: rtl/pin_entry_tx_if.sv
// Keypad/checker signal bundle for pin_entry_tx. The PIN entry block uses the
// master side because it initiates the code offer; the environment uses slave.
interface pin_entry_tx_if #(
    parameter int DIGITS = 4
);
    logic [3:0]          key;
    logic                key_stb;
    logic                enter;
    logic                clr;
    logic [4*DIGITS-1:0] code;
    logic                code_valid;
    logic                code_ready;
    logic                result_valid;
    logic                result_ok;
    logic [3:0]          digit_cnt;
    logic [1:0]          fail_cnt;
    logic                lockout;
    logic                busy;

    modport master (
        input  key, key_stb, enter, clr, code_ready, result_valid, result_ok,
        output code, code_valid, digit_cnt, fail_cnt, lockout, busy
    );

    modport slave (
        output key, key_stb, enter, clr, code_ready, result_valid, result_ok,
        input  code, code_valid, digit_cnt, fail_cnt, lockout, busy
    );
endinterface

// File: rtl/pin_entry_tx.sv
// Collects a DIGITS-long BCD PIN from key strobes, offers it to the checker,
// tracks consecutive failures and enforces a timed lockout after the third.
module pin_entry_tx #(
    parameter int DIGITS      = 4,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int LOCKOUT_CYC = 5000000
) (
    input logic            clk,
    input logic            rst,
    pin_entry_tx_if.master bus
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int LW = $clog2(LOCKOUT_CYC + 1);
    localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] IDLE_ONE  = TW'(1);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCKOUT_CYC - 1);
    localparam logic [LW-1:0] LOCK_ONE  = LW'(1);
    localparam logic [3:0]    FULL      = 4'(DIGITS);

    typedef enum logic [1:0] {COLLECT, SEND, WAIT_RES, LOCK} state_t;

    state_t              r_state;
    logic [4*DIGITS-1:0] r_code;
    logic [3:0]          r_cnt;
    logic [1:0]          r_fail;
    logic [TW-1:0]       r_idle;
    logic [LW-1:0]       r_lock;
    logic                r_code_valid;
    logic                r_lockout;
    logic                r_busy;
    logic [4*DIGITS-1:0] w_shift;

    // Shift-then-overwrite keeps this legal for DIGITS==1 as well.
    always_comb begin
        w_shift      = r_code << 4;
        w_shift[3:0] = bus.key;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= COLLECT;
            r_code       <= '0;
            r_cnt        <= '0;
            r_fail       <= '0;
            r_idle       <= '0;
            r_lock       <= '0;
            r_code_valid <= 1'b0;
            r_lockout    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                COLLECT: begin
                    if (bus.clr) begin
                        r_code <= '0;
                        r_cnt  <= '0;
                        r_idle <= '0;
                    end else if (bus.enter) begin
                        r_idle <= '0;
                        if (r_cnt == FULL) begin
                            r_state      <= SEND;
                            r_code_valid <= 1'b1;
                            r_busy       <= 1'b1;
                        end else begin
                            r_code <= '0;
                            r_cnt  <= '0;
                        end
                    end else if (bus.key_stb) begin
                        r_idle <= '0;
                        if (bus.key <= 4'd9 && r_cnt < FULL) begin
                            r_code <= w_shift;
                            r_cnt  <= r_cnt + 4'd1;
                        end
                    end else if (r_cnt != 4'd0) begin
                        // Clear lands on the TIMEOUT_CYC-th consecutive idle edge.
                        if (r_idle >= IDLE_LAST) begin
                            r_code <= '0;
                            r_cnt  <= '0;
                            r_idle <= '0;
                        end else begin
                            r_idle <= r_idle + IDLE_ONE;
                        end
                    end else begin
                        r_idle <= '0;
                    end
                end
                SEND: begin
                    if (bus.code_ready) begin
                        r_state      <= WAIT_RES;
                        r_code_valid <= 1'b0;
                    end
                end
                WAIT_RES: begin
                    if (bus.result_valid) begin
                        r_code <= '0;
                        r_cnt  <= '0;
                        r_busy <= 1'b0;
                        if (bus.result_ok) begin
                            r_fail  <= 2'd0;
                            r_state <= COLLECT;
                        end else if (r_fail < 2'd2) begin
                            r_fail  <= r_fail + 2'd1;
                            r_state <= COLLECT;
                        end else begin
                            r_fail    <= 2'd3;
                            r_lockout <= 1'b1;
                            r_lock    <= '0;
                            r_state   <= LOCK;
                        end
                    end
                end
                LOCK: begin
                    if (r_lock >= LOCK_LAST) begin
                        r_fail    <= 2'd0;
                        r_lockout <= 1'b0;
                        r_lock    <= '0;
                        r_state   <= COLLECT;
                    end else begin
                        r_lock <= r_lock + LOCK_ONE;
                    end
                end
                default: r_state <= COLLECT;
            endcase
        end
    end

    assign bus.code       = r_code;
    assign bus.code_valid = r_code_valid;
    assign bus.digit_cnt  = r_cnt;
    assign bus.fail_cnt   = r_fail;
    assign bus.lockout    = r_lockout;
    assign bus.busy       = r_busy;
endmodule
